// File: rtl/valu_ctrl_pkg.sv
// rtl/valu_ctrl_pkg.sv - shared constants and types for the vector ALU issue controller
// Purpose: ALU latency, register count, register tag type and tag-pipeline entry type.
// Ports: none (package).
package valu_ctrl_pkg;

  localparam int VALU_LAT   = 9;
  localparam int VALU_NVREG = 32;

  typedef logic [4:0] vreg_t;

  typedef struct packed {
    logic  v;
    vreg_t vd;
  } valu_tag_t;

endpackage

// File: rtl/valu_issue_ctrl_if.sv
// rtl/valu_issue_ctrl_if.sv - decode request and writeback handshake bundle
// Purpose: groups the decode-side request handshake and the writeback-side
//   result strobe of valu_issue_ctrl.
// Ports (signals):
//   req_valid/req_ready  decode handshake, req_op/req_imm/req_vd/req_vs1/req_vs2 payload
//   wb_stall             writeback back-pressure
//   wb_valid/wb_vd       result strobe and destination tag aligned with the ALU output
// Modports: master = decode/writeback side, slave = controller.
interface valu_issue_ctrl_if;
  import valu_ctrl_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [7:0]  req_imm;
  vreg_t       req_vd;
  vreg_t       req_vs1;
  vreg_t       req_vs2;
  logic        wb_stall;
  logic        wb_valid;
  vreg_t       wb_vd;

  modport master (
    output req_valid, req_op, req_imm, req_vd, req_vs1, req_vs2, wb_stall,
    input  req_ready, wb_valid, wb_vd
  );

  modport slave (
    input  req_valid, req_op, req_imm, req_vd, req_vs1, req_vs2, wb_stall,
    output req_ready, wb_valid, wb_vd
  );

endinterface

// File: rtl/valu_scoreboard.sv
// rtl/valu_scoreboard.sv - per-register pending scoreboard with 3-read hazard check
// Purpose: one pending bit per vector register; set on issue, cleared on retire,
//   wiped by flush. Hazard is the OR of three registered pending lookups.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   set_en/set_idx          mark a destination pending (issue)
//   clr_en/clr_idx          release a destination (retire)
//   flush                   clear every pending bit, overrides set/clear
//   rd_idx0..rd_idx2        registers to look up
//   hazard                  any looked-up register is pending
module valu_scoreboard
  import valu_ctrl_pkg::*;
#(
  parameter int NVREG = VALU_NVREG
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  set_en,
  input  vreg_t set_idx,
  input  logic  clr_en,
  input  vreg_t clr_idx,
  input  logic  flush,
  input  vreg_t rd_idx0,
  input  vreg_t rd_idx1,
  input  vreg_t rd_idx2,
  output logic  hazard
);

  logic [NVREG-1:0] pending_q;
  logic [NVREG-1:0] pending_d;

  // Set and clear never target the same register in one cycle: a pending
  // destination blocks issue, so only the clear can land on it.
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else begin
      if (clr_en) pending_d[clr_idx] = 1'b0;
      if (set_en) pending_d[set_idx] = 1'b1;
    end
  end

  // Reads come from the registered vector only, so a register retiring this
  // cycle still reads as pending (no bypass).
  always_comb begin
    hazard = pending_q[rd_idx0] | pending_q[rd_idx1] | pending_q[rd_idx2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

endmodule

// File: rtl/valu_issue_ctrl.sv
// rtl/valu_issue_ctrl.sv - issue/writeback controller for the 4-lane vector ALU
// Purpose: accepts decode ops, blocks RAW/WAW hazards with a pending scoreboard,
//   drives the ALU enable/op/imm and tracks in-flight ops through a tag pipeline
//   that moves in lockstep with the ALU so writeback gets a valid strobe and tag.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   bus (slave)              decode request handshake + writeback strobe/stall
//   flush                    kill all in-flight ops this cycle
//   alu_en, alu_op, alu_imm  to vector_alu
//   busy                     any op in flight
module valu_issue_ctrl
  import valu_ctrl_pkg::*;
#(
  parameter int LAT   = VALU_LAT,
  parameter int NVREG = VALU_NVREG
) (
  input  logic               clk,
  input  logic               rst_n,
  valu_issue_ctrl_if.slave   bus,
  input  logic               flush,
  output logic               alu_en,
  output logic [4:0]         alu_op,
  output logic [7:0]         alu_imm,
  output logic               busy
);

  valu_tag_t tag_q [LAT];
  valu_tag_t tag_d [LAT];

  logic hazard;
  logic issue;
  logic retire;

  assign alu_en        = ~bus.wb_stall;
  assign bus.req_ready = alu_en & ~hazard & ~flush;
  assign issue         = bus.req_valid & bus.req_ready;
  assign alu_op        = issue ? bus.req_op  : 5'd0;
  assign alu_imm       = issue ? bus.req_imm : 8'd0;

  // Flush masks the last stage so writeback never sees a killed result.
  assign bus.wb_valid  = tag_q[LAT-1].v & ~flush;
  assign bus.wb_vd     = tag_q[LAT-1].vd;
  assign retire        = bus.wb_valid & ~bus.wb_stall;

  valu_scoreboard #(
    .NVREG (NVREG)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (issue),
    .set_idx (bus.req_vd),
    .clr_en  (retire),
    .clr_idx (bus.wb_vd),
    .flush   (flush),
    .rd_idx0 (bus.req_vs1),
    .rd_idx1 (bus.req_vs2),
    .rd_idx2 (bus.req_vd),
    .hazard  (hazard)
  );

  // The tag pipeline advances only when the ALU is enabled, keeping each tag
  // beside its data through stalls.
  always_comb begin
    for (int i = 0; i < LAT; i++) tag_d[i] = tag_q[i];
    if (flush) begin
      for (int i = 0; i < LAT; i++) tag_d[i].v = 1'b0;
    end else if (alu_en) begin
      tag_d[0] = '{v: issue, vd: bus.req_vd};
      for (int i = 1; i < LAT; i++) tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LAT; i++) busy = busy | tag_q[i].v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

endmodule

// File: doc/valu_issue_ctrl.md
# valu_issue_ctrl

Issue and writeback controller for the 4-lane vector ALU (`vector_alu`, fixed 9-cycle pipeline, `en`-gated). It accepts vector ops from decode on a valid/ready handshake and blocks issue on register hazards using a per-register pending scoreboard. It drives the ALU `en`/`op`/`imm` inputs and tracks every in-flight op through a tag pipeline matched to the ALU latency. The writeback stage receives a valid strobe and destination tag aligned with `vout`/`rout`.

## Interface
- `LAT`, 9, ALU pipeline depth in enabled cycles; must equal `vector_alu` latency
- `NVREG`, 32, number of vector registers; tag width is `$clog2(NVREG)`
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  decode presents an op
- `req_ready`  out  1  op accepted on the edge where `req_valid && req_ready`
- `req_op`  in  5  ALU opcode
- `req_imm`  in  8  immediate
- `req_vd`  in  5  destination vector register
- `req_vs1`, `req_vs2`  in  5 each  source vector registers
- `wb_stall`  in  1  writeback cannot accept a result this cycle
- `flush`  in  1  kill all in-flight ops (branch/exception)
- `alu_en`  out  1  to `vector_alu.en`
- `alu_op`  out  5  to `vector_alu.op`
- `alu_imm`  out  8  to `vector_alu.imm`
- `wb_valid`  out  1  `vout`/`rout` hold a live result this cycle
- `wb_vd`  out  5  destination tag for that result
- `busy`  out  1  any op in flight

## Operation
- Tag pipeline: `LAT` stages of {valid, vd}. Shifts one stage on every edge where `alu_en`=1, in lockstep with the ALU. Stage 0 loads {issue, req_vd}.
- `alu_en` = ~`wb_stall`. A stall freezes both the ALU and the tag pipeline, so alignment with the ALU is never lost.
- Scoreboard: `NVREG`-bit pending vector, registered.
- Hazard: pending[vs1] | pending[vs2] | pending[vd]. This covers RAW and WAW, so at most one op per vd is in flight.
- `req_ready` = `alu_en` & ~hazard & ~`flush`.
- issue = `req_valid` & `req_ready`. `alu_op`/`alu_imm` = `req_op`/`req_imm` when issue, else 0.
- retire = `wb_valid` & ~`wb_stall`. On the retire edge, pending[`wb_vd`] clears.
- Issue edge: pending[vd] sets.
- No bypass: a reg that retires at edge E is issuable only from the cycle after E. This costs a one-cycle bubble, and a same-cycle set/clear conflict cannot occur.
- `wb_valid` = last stage valid & ~`flush`. `wb_vd` = last stage vd.
- `busy` = OR of stage valids.
- Flush (synchronous, highest priority): on the edge it is sampled, clear all stage valids and the whole scoreboard. There is no issue and no retire that cycle.
- Reset: all stage valids, all vd fields and the scoreboard go to 0.
  - Combinational outputs after reset: `req_ready`=1 (if `wb_stall`=0), `alu_en`=~`wb_stall`, `alu_op`=0, `alu_imm`=0, `wb_valid`=0, `wb_vd`=0, `busy`=0.
  - Reset asserted mid-operation discards all in-flight ops. The ALU's own contents are don't-care because no valid is tracked for them.

## Timing
- Issue at edge T with no stall: `wb_valid` is high in the cycle after edge T+`LAT`−1, i.e. exactly `LAT` enabled edges after issue (9 for default).
- Each stalled cycle adds one cycle of latency. While stalled, `wb_valid`/`wb_vd` hold steady.
- Back-to-back independent issue sustains one op per cycle.
- Dependent op (vs1 = previous vd): earliest issue is the cycle after the producer's retire edge.
- Back-to-back `req_valid` with hazard: `req_ready` stays low; decode must hold the request stable.

## Structure
- `valu_ctrl_pkg`:
  - `VALU_LAT`=9, `VALU_NVREG`=32
  - `typedef logic [4:0] vreg_t`
  - `typedef struct packed {logic v; vreg_t vd;} valu_tag_t`
- Sub-module `valu_scoreboard`: pending vector with set/clear/flush ports and a 3-read combinational hazard output.
- Tag pipeline and glue logic live in the top module.

## Test plan
- Reset mid-run with 3 ops in flight → next cycle `busy`=0, `wb_valid`=0, `req_ready`=1; earlier tags never appear on `wb_vd`.
- Single issue vd=4, op=5'h03, no stall → `wb_valid`=1, `wb_vd`=4 exactly 9 cycles later for one cycle; pending[4] is clear afterwards.
- Dependent pair: vd=2, then vs1=2 vd=3 presented the next cycle → `req_ready`=0 until the cycle after vd=2 retires; second result arrives 9 cycles after its own issue.
- Four independent ops vd=1..4 back-to-back → four consecutive `wb_valid` cycles with tags 1,2,3,4.
- `wb_stall` held 3 cycles while `wb_valid`=1 with vd=7 → `alu_en`=0, `wb_vd` holds 7, no issue; retire occurs on the first unstalled edge and all later results shift by 3 cycles.
- Flush with vd=5 at stage 8 and vd=6 at stage 2 → `wb_valid` forced 0 that cycle; both are gone afterwards; a request with vs1=5 is accepted the next cycle.
